// File: rtl/ram_mem_banked_16b.sv
// ram_mem_banked_16b: simulation backing store for the RS5 core memory port.
// Each access covers word addr_i and word (addr_i+1) mod MEM_WIDTH as one
// 2*WORD_WIDTH bus word, with per-byte write enables, a req/gnt/rvalid
// handshake with WAIT_STATES extra cycles, and per-byte written flags so that
// never-written bytes read as zero (ZERO_UNWRITTEN=1).
//
// Ports:
//   clk       clock
//   rst       asynchronous reset, active-low
//   req_i     access request
//   we_i      1 = write, 0 = read
//   be_i      byte enables; low half -> word addr_i, high half -> addr_i+1
//   addr_i    word address
//   data_i    write data; low half -> addr_i, high half -> addr_i+1
//   gnt_o     request accepted this cycle (combinational)
//   rvalid_o  one-cycle response pulse for reads and writes
//   rdata_o   {word[addr_i+1], word[addr_i]} captured on read responses
//   err_o     with rvalid_o: addr_i >= MEM_WIDTH
//   busy_o    FSM not idle
module ram_mem_banked_16b #(
    parameter int unsigned MEM_WIDTH      = 65536,
    parameter int unsigned WORD_WIDTH     = 16,
    parameter int unsigned WAIT_STATES    = 0,
    parameter bit          ZERO_UNWRITTEN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_i,
    input  logic                          we_i,
    input  logic [2*WORD_WIDTH/8-1:0]     be_i,
    input  logic [$clog2(MEM_WIDTH)-1:0]  addr_i,
    input  logic [2*WORD_WIDTH-1:0]       data_i,
    output logic                          gnt_o,
    output logic                          rvalid_o,
    output logic [2*WORD_WIDTH-1:0]       rdata_o,
    output logic                          err_o,
    output logic                          busy_o
);
    localparam int unsigned AW  = $clog2(MEM_WIDTH);
    localparam int unsigned BPW = WORD_WIDTH / 8;
    localparam int unsigned BW  = 2 * WORD_WIDTH;
    localparam int unsigned NBE = 2 * BPW;

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q;
    logic [NBE-1:0]   be_q;
    logic [AW-1:0]    addr_q;
    logic [BW-1:0]    data_q;
    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;
    logic [BW-1:0]    rdata_q, rdata_d;

    logic [WORD_WIDTH-1:0] mem [MEM_WIDTH];
    logic [BPW-1:0]        written_q [MEM_WIDTH];

    logic             acc_en;
    logic             acc_we;
    logic             acc_err;
    logic [NBE-1:0]   acc_be;
    logic [AW-1:0]    acc_lo;
    logic [AW-1:0]    acc_hi;
    logic [BW-1:0]    acc_data;
    logic [BW-1:0]    rd_raw;
    logic [BW-1:0]    rd_mask;

    assign gnt_o    = req_i && (state_q == S_IDLE);
    assign busy_o   = (state_q != S_IDLE);
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

    // With no wait states the access happens on the acceptance edge straight
    // from the ports; otherwise it uses the request latched at acceptance.
    always_comb begin
        if (WAIT_STATES == 0) begin
            acc_en   = gnt_o;
            acc_we   = we_i;
            acc_be   = be_i;
            acc_lo   = addr_i;
            acc_data = data_i;
        end else begin
            acc_en   = (state_q == S_WAIT) && (cnt_q == '0);
            acc_we   = we_q;
            acc_be   = be_q;
            acc_lo   = addr_q;
            acc_data = data_q;
        end
        acc_err = (32'(acc_lo) >= MEM_WIDTH);
        // Upper half wraps to word 0 at the top of the array.
        acc_hi  = (32'(acc_lo) + 32'd1 >= MEM_WIDTH) ? '0 : acc_lo + AW'(1);
    end

    always_comb begin
        rd_raw  = {mem[acc_hi], mem[acc_lo]};
        rd_mask = '1;
        if (ZERO_UNWRITTEN) begin
            for (int unsigned i = 0; i < BPW; i++) begin
                rd_mask[8*i +: 8]            = {8{written_q[acc_lo][i]}};
                rd_mask[WORD_WIDTH+8*i +: 8] = {8{written_q[acc_hi][i]}};
            end
        end
    end

    always_comb begin
        rvalid_d = acc_en;
        err_d    = acc_en && acc_err;
        rdata_d  = rdata_q;
        if (acc_en) begin
            if (acc_err) begin
                rdata_d = '0;
            end else if (!acc_we) begin
                rdata_d = rd_raw & rd_mask;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_o && (WAIT_STATES != 0)) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            if (gnt_o) begin
                we_q   <= we_i;
                be_q   <= be_i;
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    // Array contents survive reset; only the written flags are cleared.
    always_ff @(posedge clk) begin
        if (acc_en && acc_we && !acc_err) begin
            for (int unsigned i = 0; i < BPW; i++) begin
                if (acc_be[i])
                    mem[acc_lo][8*i +: 8] <= acc_data[8*i +: 8];
                if (acc_be[BPW+i])
                    mem[acc_hi][8*i +: 8] <= acc_data[WORD_WIDTH+8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned w = 0; w < MEM_WIDTH; w++)
                written_q[w] <= '0;
        end else if (acc_en && acc_we && !acc_err) begin
            for (int unsigned i = 0; i < BPW; i++) begin
                if (acc_be[i])
                    written_q[acc_lo][i] <= 1'b1;
                if (acc_be[BPW+i])
                    written_q[acc_hi][i] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_mem_banked_16b.sv
// Testbench for ram_mem_banked_16b: two instances (65536 words / no wait
// states, 1000 words / 3 wait states) checked every cycle against a
// byte-addressed reference model, plus directed literal expectations.
module tb_ram_mem_banked_16b;
    localparam int MW0 = 65536;
    localparam int MW1 = 1000;
    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [3:0]  be0 = '0, be1 = '0;
    logic [15:0] addr0 = '0;
    logic [9:0]  addr1 = '0;
    logic [31:0] data0 = '0, data1 = '0;
    logic        gnt0, rv0, err0, busy0, gnt1, rv1, err1, busy1;
    logic [31:0] rd0, rd1;

    ram_mem_banked_16b #(.MEM_WIDTH(MW0), .WORD_WIDTH(16), .WAIT_STATES(WS0), .ZERO_UNWRITTEN(1'b1)) u_d0 (
        .clk(clk), .rst(rst0), .req_i(req0), .we_i(we0), .be_i(be0), .addr_i(addr0), .data_i(data0),
        .gnt_o(gnt0), .rvalid_o(rv0), .rdata_o(rd0), .err_o(err0), .busy_o(busy0));

    ram_mem_banked_16b #(.MEM_WIDTH(MW1), .WORD_WIDTH(16), .WAIT_STATES(WS1), .ZERO_UNWRITTEN(1'b1)) u_d1 (
        .clk(clk), .rst(rst1), .req_i(req1), .we_i(we1), .be_i(be1), .addr_i(addr1), .data_i(data1),
        .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1), .err_o(err1), .busy_o(busy1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed store; a missing key is an unwritten byte.
    logic [7:0]  mm0 [int];
    logic [7:0]  mm1 [int];
    bit          pend [2];
    int          due [2];
    bit          p_we [2];
    logic [3:0]  p_be [2];
    int          p_addr [2];
    logic [31:0] p_dat [2];
    logic [31:0] last_rd [2];
    int          cyc = 0;

    function automatic int mw(input int k);
        return (k == 0) ? MW0 : MW1;
    endfunction

    function automatic int ws(input int k);
        return (k == 0) ? WS0 : WS1;
    endfunction

    // Byte b of the bus word at word address a: bytes 0,1 from a, 2,3 from a+1.
    function automatic int baddr(input int k, input int a, input int b);
        int w;
        w = (b < 2) ? a : (a + 1) % mw(k);
        return w * 2 + (b % 2);
    endfunction

    function automatic logic [7:0] mget(input int k, input int key);
        if (k == 0) return mm0.exists(key) ? mm0[key] : 8'h00;
        return mm1.exists(key) ? mm1[key] : 8'h00;
    endfunction

    function automatic void mset(input int k, input int key, input logic [7:0] v);
        if (k == 0) mm0[key] = v;
        else        mm1[key] = v;
    endfunction

    task automatic step(input int k, input logic rst, input logic req, input logic we,
                        input logic [3:0] be, input int a, input logic [31:0] d,
                        input logic gnt, input logic rv, input logic err,
                        input logic busy, input logic [31:0] rd);
        logic  e_rv, e_err;
        string s;
        e_rv  = 1'b0;
        e_err = 1'b0;
        s     = (k == 0) ? "d0" : "d1";
        if (!rst) begin
            pend[k]    = 1'b0;
            last_rd[k] = '0;
            if (k == 0) mm0.delete();
            else        mm1.delete();
        end else if (pend[k] && due[k] == cyc) begin
            pend[k] = 1'b0;
            e_rv    = 1'b1;
            if (p_addr[k] >= mw(k)) begin
                e_err      = 1'b1;
                last_rd[k] = '0;
            end else if (p_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (p_be[k][b]) mset(k, baddr(k, p_addr[k], b), p_dat[k][8*b +: 8]);
            end else begin
                for (int b = 0; b < 4; b++)
                    last_rd[k][8*b +: 8] = mget(k, baddr(k, p_addr[k], b));
            end
        end
        cmp({s, ".gnt"},    32'(gnt),  32'(req && !pend[k]));
        cmp({s, ".rvalid"}, 32'(rv),   32'(e_rv));
        cmp({s, ".err"},    32'(err),  32'(e_err));
        cmp({s, ".busy"},   32'(busy), 32'(pend[k]));
        cmp({s, ".rdata"},  rd,        last_rd[k]);
        if (rst && req && !pend[k]) begin
            pend[k]   = 1'b1;
            due[k]    = cyc + 1 + ws(k);
            p_we[k]   = we;
            p_be[k]   = be;
            p_addr[k] = a;
            p_dat[k]  = d;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            step(0, rst0, req0, we0, be0, int'(addr0), data0, gnt0, rv0, err0, busy0, rd0);
            step(1, rst1, req1, we1, be1, int'(addr1), data1, gnt1, rv1, err1, busy1, rd1);
        end
    end

    // One access on instance k; returns rdata/err at the response and the
    // cycles waited for grant and for rvalid after acceptance.
    task automatic acc(input int k, input logic w, input logic [3:0] b, input int a,
                       input logic [31:0] d, output logic [31:0] r, output logic e,
                       output int gw, output int rw);
        @(posedge clk); #1;
        if (k == 0) begin req0 = 1'b1; we0 = w; be0 = b; addr0 = 16'(a); data0 = d; end
        else        begin req1 = 1'b1; we1 = w; be1 = b; addr1 = 10'(a); data1 = d; end
        #1;
        gw = 0;
        while (!((k == 0) ? gnt0 : gnt1) && gw < 50) begin
            @(posedge clk); #2;
            gw++;
        end
        if (gw >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL acc.gnt_timeout: got no grant, want one within 50 cycles");
        end
        @(posedge clk); #1;
        if (k == 0) req0 = 1'b0;
        else        req1 = 1'b0;
        rw = 0;
        while (!((k == 0) ? rv0 : rv1) && rw < 50) begin
            @(posedge clk); #1;
            rw++;
        end
        if (rw >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL acc.rv_timeout: got no rvalid, want one within 50 cycles");
        end
        r = (k == 0) ? rd0 : rd1;
        e = (k == 0) ? err0 : err1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, want finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          gw, rw;
        logic [8:0]  gp, vp;

        #1 rst0 = 1'b0; rst1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst0 = 1'b1; rst1 = 1'b1;

        // No wait states: grant same cycle, rvalid next cycle.
        acc(0, 1'b0, 4'hF, 16'h0010, 32'h0, r, e, gw, rw);
        cmp("t1.rdata", r, 32'h0000_0000);
        cmp("t1.err", 32'(e), 32'd0);
        cmp("t1.gnt_wait", gw, 0);
        cmp("t1.rv_wait", rw, 0);

        acc(0, 1'b1, 4'hF, 16'h0010, 32'hBEEF_CAFE, r, e, gw, rw);
        acc(0, 1'b0, 4'hF, 16'h0010, 32'h0, r, e, gw, rw);
        cmp("t2.rd10", r, 32'hBEEF_CAFE);
        acc(0, 1'b0, 4'hF, 16'h0011, 32'h0, r, e, gw, rw);
        cmp("t2.rd11", r, 32'h0000_BEEF);

        acc(0, 1'b1, 4'b0101, 16'h0020, 32'h1122_3344, r, e, gw, rw);
        acc(0, 1'b0, 4'hF, 16'h0020, 32'h0, r, e, gw, rw);
        cmp("t3.rd20", r, 32'h0022_0044);

        acc(0, 1'b1, 4'hF, 16'hFFFF, 32'hAAAA_5555, r, e, gw, rw);
        acc(0, 1'b0, 4'hF, 16'h0000, 32'h0, r, e, gw, rw);
        cmp("t4.rd0000", r, 32'h0000_AAAA);
        acc(0, 1'b0, 4'hF, 16'hFFFF, 32'h0, r, e, gw, rw);
        cmp("t4.rdFFFF", r, 32'hAAAA_5555);

        // be=0 write leaves the word alone.
        acc(0, 1'b1, 4'h0, 16'h0010, 32'h0, r, e, gw, rw);
        acc(0, 1'b0, 4'hF, 16'h0010, 32'h0, r, e, gw, rw);
        cmp("t5.be0", r, 32'hBEEF_CAFE);

        // Write then read of the same address on consecutive cycles.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; be0 = 4'hF; addr0 = 16'h0030; data0 = 32'h1234_5678;
        @(posedge clk); #1 we0 = 1'b0;
        @(posedge clk); #1 req0 = 1'b0;
        cmp("t6.rv", 32'(rv0), 32'd1);
        cmp("t6.rdata", rd0, 32'h1234_5678);

        // Three wait states, request held for back-to-back reads.
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b0; be1 = 4'hF; addr1 = 10'd7;
        for (int i = 0; i < 9; i++) begin
            #1;
            gp[i] = gnt1;
            vp[i] = rv1;
            if (i == 8) req1 = 1'b0;
            @(posedge clk); #1;
        end
        cmp("t7.gnt_pattern", 32'(gp), 32'h111);
        cmp("t7.rv_pattern",  32'(vp), 32'h110);
        repeat (5) @(posedge clk);

        acc(1, 1'b0, 4'hF, 5, 32'h0, r, e, gw, rw);
        cmp("t8.rv_wait", rw, 3);

        // Reset while a write is in flight drops it.
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b1; be1 = 4'hF; addr1 = 10'd5; data1 = 32'h1234_5678;
        #1 cmp("t9.gnt", 32'(gnt1), 32'd1);
        @(posedge clk); #1 req1 = 1'b0;
        @(posedge clk); #1 rst1 = 1'b0;
        #1;
        cmp("t9.busy", 32'(busy1), 32'd0);
        cmp("t9.rv", 32'(rv1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b1;
        repeat (4) @(posedge clk);
        acc(1, 1'b0, 4'hF, 5, 32'h0, r, e, gw, rw);
        cmp("t9.rdata", r, 32'h0);

        // Out-of-range address on the 1000-word instance.
        acc(1, 1'b0, 4'hF, 1000, 32'h0, r, e, gw, rw);
        cmp("t10.err", 32'(e), 32'd1);
        cmp("t10.rdata", r, 32'h0);

        // Wrap at the top of a non-power-of-2 array.
        acc(1, 1'b1, 4'hF, 999, 32'hCAFE_0BAD, r, e, gw, rw);
        acc(1, 1'b0, 4'hF, 0, 32'h0, r, e, gw, rw);
        cmp("t11.rd0", r, 32'h0000_CAFE);
        acc(1, 1'b0, 4'hF, 999, 32'h0, r, e, gw, rw);
        cmp("t11.rd999", r, 32'hCAFE_0BAD);
        cmp("t11.err", 32'(e), 32'd0);

        repeat (6) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_mem_banked_16b.md
Name: ram_mem_banked_16b

Overview:
Parametrised simulation RAM of WORD_WIDTH-bit words. Each access covers word addr_i and word addr_i+1, read or written together as one 2*WORD_WIDTH bus word.
It adds per-byte write enables, a req/gnt/rvalid handshake with configurable wait states, and per-byte written-tracking so unwritten bytes read as zero.
It sits between the RS5 core memory interface and the testbench as the data/instruction backing store.

Parameters:
MEM_WIDTH, 65536, number of WORD_WIDTH-bit words; any value >= 2, need not be a power of 2
WORD_WIDTH, 16, bits per word; must be a multiple of 8
WAIT_STATES, 0, extra cycles between grant and access; legal range 0..15
ZERO_UNWRITTEN, 1, when 1, unwritten bytes read 0; when 0, raw array contents are returned

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
req_i  in  1  access request
we_i  in  1  1 = write, 0 = read
be_i  in  2*WORD_WIDTH/8  byte enables; low WORD_WIDTH/8 bits select word addr_i, high bits select word addr_i+1
addr_i  in  $clog2(MEM_WIDTH)  word address
data_i  in  2*WORD_WIDTH  write data; low half goes to addr_i, high half to addr_i+1
gnt_o  out  1  request accepted this cycle
rvalid_o  out  1  one-cycle response pulse, for both reads and writes
rdata_o  out  2*WORD_WIDTH  {word[addr_i+1], word[addr_i]}; valid only with rvalid_o on reads
err_o  out  1  with rvalid_o: addr_i >= MEM_WIDTH
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; rvalid_o, rdata_o, err_o, busy_o and the wait counter go to 0.
  - All byte-written flags are cleared; array contents are untouched.
  - An in-flight request is dropped: no write is performed and no response is issued.
- gnt_o = req_i && state==IDLE (combinational). A request is accepted on the clk edge where gnt_o=1. addr/we/be/data are latched at acceptance; later input changes are ignored.
- FSM states: IDLE, WAIT.
  - WAIT_STATES=0: the access is performed on the acceptance edge. rvalid_o is high the next cycle. FSM stays in IDLE, so one access per cycle is possible.
  - WAIT_STATES=N>0: IDLE -> WAIT on acceptance, with the counter loaded to N-1. In WAIT the counter decrements each cycle. The access is performed on the edge where the counter is 0, and the FSM returns to IDLE on that same edge. rvalid_o is high the following cycle, i.e. N+1 cycles after acceptance. gnt_o is 0 throughout WAIT.
- Second address = (addr_i+1) mod MEM_WIDTH, so an access at MEM_WIDTH-1 wraps its upper half to word 0.
- Write:
  - Each byte whose be bit is 1 is written to the array and its written flag is set.
  - Bytes with be=0 are unchanged.
  - be=0 produces no change but still returns an rvalid_o pulse.
  - rdata_o holds its previous value on a write response.
- Read:
  - rdata_o is captured at access time.
  - With ZERO_UNWRITTEN=1, any byte whose flag is clear reads 8'h00.
  - rdata_o holds its value until the next read response.
- Error: if addr_i >= MEM_WIDTH (possible only for non-power-of-2 sizes):
  - No array or flag update is made.
  - rdata_o = 0, and err_o = 1 together with rvalid_o.
- err_o is 0 whenever rvalid_o is 0.
- A write followed by a read of the same address returns the new data; there are no stale-read hazards.
- busy_o = (state != IDLE).

Test Plan:
- Reset, then read addr 0x0010 with WAIT_STATES=0 -> gnt_o=1 same cycle, rvalid_o next cycle, rdata_o=32'h0000_0000, err_o=0.
- Write addr 0x0010, data 32'hBEEF_CAFE, be=4'b1111, then read 0x0010 -> rdata_o=32'hBEEF_CAFE. Read 0x0011 -> rdata_o=32'h0000_BEEF.
- Write addr 0x0020, data 32'h1122_3344, be=4'b0101, then read 0x0020 -> rdata_o=32'h0022_0044.
- Write addr 0xFFFF, data 32'hAAAA_5555 (MEM_WIDTH=65536), then read 0x0000 -> rdata_o low half=16'hAAAA; read 0xFFFF -> rdata_o=32'hAAAA_5555.
- WAIT_STATES=3: hold req_i high for two back-to-back reads -> first gnt at t0, rvalid at t0+4, gnt_o=0 at t0+1..t0+3, second gnt at t0+4, rvalid at t0+8.
- WAIT_STATES=3: write accepted at t0, rst=0 at t0+2 -> no rvalid_o, busy_o=0 immediately. After reset release, read of that address returns 0. With MEM_WIDTH=1000, a read at addr 1000 -> rvalid_o=1, err_o=1, rdata_o=0.
